// File: rtl/object_physics_mover.sv
// Per-frame fixed-point trajectory engine for one sprite: gravity, saturated Y speed,
// key/collision reactions and bounce/wrap/stop screen-edge handling.
module object_physics_mover #(
    parameter int INITIAL_X       = 280,
    parameter int INITIAL_Y       = 185,
    parameter int INITIAL_X_SPEED = 40,
    parameter int INITIAL_Y_SPEED = 20,
    parameter int Y_ACCEL         = 5,
    parameter int MAX_Y_SPEED     = 400,
    parameter int FRAC_BITS       = 6,
    parameter int OBJ_W           = 64,
    parameter int OBJ_H           = 64,
    parameter int SCREEN_W        = 640,
    parameter int SCREEN_H        = 480,
    parameter int MARGIN          = 2,
    parameter int EDGE_MODE       = 0
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               enable,
    input  logic               restart,
    input  logic               Y_direction_key,
    input  logic               toggle_x_key,
    input  logic               collision,
    input  logic [3:0]         HitEdgeCode,
    output logic signed [10:0] topLeftX,
    output logic signed [10:0] topLeftY,
    output logic [3:0]         edgeFlags,
    output logic               moving
);

    localparam int SCALE    = 1 << FRAC_BITS;
    localparam int LIM_L    = MARGIN * SCALE;
    localparam int LIM_R    = (SCREEN_W - 1 - MARGIN - OBJ_W) * SCALE;
    localparam int LIM_T    = MARGIN * SCALE;
    localparam int LIM_B    = (SCREEN_H - 1 - MARGIN - OBJ_H) * SCALE;
    localparam int WRAP_XLO = -OBJ_W * SCALE;
    localparam int WRAP_XHI = (SCREEN_W - 1) * SCALE;
    localparam int WRAP_YLO = -OBJ_H * SCALE;
    localparam int WRAP_YHI = (SCREEN_H - 1) * SCALE;

    typedef enum logic [2:0] {
        IDLE_ST,
        MOVE_ST,
        WAIT_FOR_EOF_ST,
        POSITION_CHANGE_ST,
        POSITION_LIMITS_ST
    } state_t;

    state_t             r_state, w_next;
    logic signed [31:0] r_x, r_y, r_xs, r_ys;
    logic               r_toggle_d;
    logic               r_load_pend;
    logic [3:0]         r_edge_pend;

    logic               w_flip_x, w_flip_y;
    logic signed [31:0] w_ys_acc, w_ys_sat;
    logic signed [31:0] w_x_lim, w_y_lim, w_xs_lim, w_ys_lim;
    logic [3:0]         w_flags;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) r_state <= IDLE_ST;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE_ST:            if (startOfFrame) w_next = MOVE_ST;
            MOVE_ST: begin
                if (startOfFrame && enable) w_next = POSITION_CHANGE_ST;
                else if (collision)         w_next = WAIT_FOR_EOF_ST;
            end
            WAIT_FOR_EOF_ST:    if (startOfFrame && enable) w_next = POSITION_CHANGE_ST;
            POSITION_CHANGE_ST: w_next = POSITION_LIMITS_ST;
            POSITION_LIMITS_ST: w_next = MOVE_ST;
            default:            w_next = IDLE_ST;
        endcase
        if (restart) w_next = IDLE_ST;
    end

    assign w_flip_y = (Y_direction_key && r_ys > 0) ||
                      (collision && ((HitEdgeCode[2] && r_ys < 0) || (HitEdgeCode[0] && r_ys > 0)));
    assign w_flip_x = (toggle_x_key && !r_toggle_d) ||
                      (collision && ((HitEdgeCode[3] && r_xs < 0) || (HitEdgeCode[1] && r_xs > 0)));

    assign w_ys_acc = r_ys + Y_ACCEL;
    assign w_ys_sat = (w_ys_acc > MAX_Y_SPEED)  ? MAX_Y_SPEED :
                      (w_ys_acc < -MAX_Y_SPEED) ? -MAX_Y_SPEED : w_ys_acc;

    always_comb begin
        w_x_lim  = r_x;
        w_y_lim  = r_y;
        w_xs_lim = r_xs;
        w_ys_lim = r_ys;
        w_flags  = '0;
        if (EDGE_MODE == 1) begin
            if (r_x < WRAP_XLO)      begin w_x_lim = WRAP_XHI; w_flags[3] = 1'b1; end
            else if (r_x > WRAP_XHI) begin w_x_lim = WRAP_XLO; w_flags[1] = 1'b1; end
            if (r_y < WRAP_YLO)      begin w_y_lim = WRAP_YHI; w_flags[2] = 1'b1; end
            else if (r_y > WRAP_YHI) begin w_y_lim = WRAP_YLO; w_flags[0] = 1'b1; end
        end else begin
            // Bounce reflects only outward motion; stop kills the axis speed.
            if (r_x < LIM_L) begin
                w_x_lim = LIM_L; w_flags[3] = 1'b1;
                if (EDGE_MODE == 2)  w_xs_lim = '0;
                else if (r_xs < 0)   w_xs_lim = -r_xs;
            end else if (r_x > LIM_R) begin
                w_x_lim = LIM_R; w_flags[1] = 1'b1;
                if (EDGE_MODE == 2)  w_xs_lim = '0;
                else if (r_xs > 0)   w_xs_lim = -r_xs;
            end
            if (r_y < LIM_T) begin
                w_y_lim = LIM_T; w_flags[2] = 1'b1;
                if (EDGE_MODE == 2)  w_ys_lim = '0;
                else if (r_ys < 0)   w_ys_lim = -r_ys;
            end else if (r_y > LIM_B) begin
                w_y_lim = LIM_B; w_flags[0] = 1'b1;
                if (EDGE_MODE == 2)  w_ys_lim = '0;
                else if (r_ys > 0)   w_ys_lim = -r_ys;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_x         <= '0;
            r_y         <= '0;
            r_xs        <= '0;
            r_ys        <= '0;
            r_toggle_d  <= 1'b0;
            r_load_pend <= 1'b0;
            r_edge_pend <= '0;
            topLeftX    <= '0;
            topLeftY    <= '0;
            edgeFlags   <= '0;
            moving      <= 1'b0;
        end else begin
            r_toggle_d  <= toggle_x_key;
            r_load_pend <= (r_state == POSITION_LIMITS_ST);
            moving      <= (w_next != IDLE_ST);
            case (r_state)
                IDLE_ST: begin
                    r_x      <= INITIAL_X * SCALE;
                    r_y      <= INITIAL_Y * SCALE;
                    r_xs     <= INITIAL_X_SPEED;
                    r_ys     <= INITIAL_Y_SPEED;
                    topLeftX <= 11'(INITIAL_X);
                    topLeftY <= 11'(INITIAL_Y);
                end
                MOVE_ST: begin
                    if (w_flip_y) r_ys <= -r_ys;
                    if (w_flip_x) r_xs <= -r_xs;
                end
                POSITION_CHANGE_ST: begin
                    r_x  <= r_x + r_xs;
                    r_y  <= r_y + r_ys;
                    r_ys <= w_ys_sat;
                end
                POSITION_LIMITS_ST: begin
                    r_x         <= w_x_lim;
                    r_y         <= w_y_lim;
                    r_xs        <= w_xs_lim;
                    r_ys        <= w_ys_lim;
                    r_edge_pend <= w_flags;
                end
                default: ;
            endcase
            // Outputs follow one cycle after the clamp so the raw sum never shows.
            if (r_load_pend && r_state != IDLE_ST) begin
                topLeftX  <= 11'(r_x >>> FRAC_BITS);
                topLeftY  <= 11'(r_y >>> FRAC_BITS);
                edgeFlags <= r_edge_pend;
            end
        end
    end

endmodule

// File: tb/tb_object_physics_mover.sv
// Randomized scoreboard bench: three movers (bounce/wrap/stop) share stimulus and are
// checked against a frame-level reference model.
module tb_object_physics_mover;

    logic clk = 1'b0;
    logic resetN, startOfFrame, enable, restart, ykey, tkey, coll;
    logic [3:0] code;
    logic [2:0][10:0] tlx, tly;
    logic [2:0][3:0]  eflg;
    logic [2:0]       mov;

    always #5 clk = ~clk;

    object_physics_mover #(.EDGE_MODE(0)) u_bounce (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .enable(enable), .restart(restart),
        .Y_direction_key(ykey), .toggle_x_key(tkey), .collision(coll), .HitEdgeCode(code),
        .topLeftX(tlx[0]), .topLeftY(tly[0]), .edgeFlags(eflg[0]), .moving(mov[0]));
    object_physics_mover #(.INITIAL_X(573), .INITIAL_X_SPEED(64), .INITIAL_Y_SPEED(398), .EDGE_MODE(1)) u_wrap (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .enable(enable), .restart(restart),
        .Y_direction_key(ykey), .toggle_x_key(tkey), .collision(coll), .HitEdgeCode(code),
        .topLeftX(tlx[1]), .topLeftY(tly[1]), .edgeFlags(eflg[1]), .moving(mov[1]));
    object_physics_mover #(.INITIAL_X(573), .INITIAL_X_SPEED(64), .INITIAL_Y_SPEED(398), .EDGE_MODE(2)) u_stop (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .enable(enable), .restart(restart),
        .Y_direction_key(ykey), .toggle_x_key(tkey), .collision(coll), .HitEdgeCode(code),
        .topLeftX(tlx[2]), .topLeftY(tly[2]), .edgeFlags(eflg[2]), .moving(mov[2]));

    int P_IX[3]   = '{280, 573, 573};
    int P_IY[3]   = '{185, 185, 185};
    int P_IXS[3]  = '{40, 64, 64};
    int P_IYS[3]  = '{20, 398, 398};
    int P_MODE[3] = '{0, 1, 2};

    int m_x[3], m_y[3], m_xs[3], m_ys[3];
    bit waiting;

    typedef struct {int due; int inst; int ex; int ey; int ef;} exp_t;
    exp_t sb[$];

    int cyc = 0;
    int n_pass = 0, n_total = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_x[i] = P_IX[i] * 64;  m_y[i] = P_IY[i] * 64;
            m_xs[i] = P_IXS[i];     m_ys[i] = P_IYS[i];
        end
        waiting = 0;
    endtask

    task automatic limit_axis(input int mode, input int lo, input int hi, input int wlo, input int whi,
                              inout int p, inout int s, output bit f_lo, output bit f_hi);
        f_lo = 0; f_hi = 0;
        if (mode == 1) begin
            if (p < wlo)      begin p = whi; f_lo = 1; end
            else if (p > whi) begin p = wlo; f_hi = 1; end
        end else if (p < lo) begin
            p = lo; f_lo = 1; s = (mode == 2) ? 0 : (s < 0 ? -s : s);
        end else if (p > hi) begin
            p = hi; f_hi = 1; s = (mode == 2) ? 0 : (s > 0 ? -s : s);
        end
    endtask

    task automatic model_frame(input int i, input int due);
        bit xl, xh, yl, yh;
        exp_t e;
        m_x[i] += m_xs[i];
        m_y[i] += m_ys[i];
        m_ys[i] += 5;
        if (m_ys[i] > 400)  m_ys[i] = 400;
        if (m_ys[i] < -400) m_ys[i] = -400;
        limit_axis(P_MODE[i], 2*64, 573*64, -64*64, 639*64, m_x[i], m_xs[i], xl, xh);
        limit_axis(P_MODE[i], 2*64, 413*64, -64*64, 479*64, m_y[i], m_ys[i], yl, yh);
        e.due = due; e.inst = i;
        e.ex = (m_x[i] >>> 6) & 'h7FF;
        e.ey = (m_y[i] >>> 6) & 'h7FF;
        e.ef = {28'd0, xl, yl, xh, yh};
        sb.push_back(e);
    endtask

    task automatic model_move(input bit yk, input bit tog, input bit c, input logic [3:0] hc);
        bit fx, fy;
        if (waiting) return;
        for (int i = 0; i < 3; i++) begin
            fy = (yk && m_ys[i] > 0) || (c && ((hc[2] && m_ys[i] < 0) || (hc[0] && m_ys[i] > 0)));
            fx = tog || (c && ((hc[3] && m_xs[i] < 0) || (hc[1] && m_xs[i] > 0)));
            if (fy) m_ys[i] = -m_ys[i];
            if (fx) m_xs[i] = -m_xs[i];
        end
        if (c) waiting = 1;
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            if (e.due != cyc) check("due_cycle", cyc, e.due);
            else begin
                check($sformatf("topLeftX[%0d]", e.inst), int'(tlx[e.inst]), e.ex);
                check($sformatf("topLeftY[%0d]", e.inst), int'(tly[e.inst]), e.ey);
                check($sformatf("edgeFlags[%0d]", e.inst), int'(eflg[e.inst]), e.ef);
                check($sformatf("moving[%0d]", e.inst), int'(mov[e.inst]), 1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_initial(input string tag, input int exp_moving);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_x[%0d]", tag, i), int'(tlx[i]), P_IX[i]);
            check($sformatf("%s_y[%0d]", tag, i), int'(tly[i]), P_IY[i]);
            check($sformatf("%s_moving[%0d]", tag, i), int'(mov[i]), exp_moving);
        end
    endtask

    initial begin
        bit yk, tg, cl, prev_tg, en;
        logic [3:0] hc;
        int k;
        resetN = 0; startOfFrame = 0; enable = 1; restart = 0;
        ykey = 0; tkey = 0; coll = 0; code = '0;
        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_x[%0d]", i), int'(tlx[i]), 0);
            check($sformatf("rst_y[%0d]", i), int'(tly[i]), 0);
            check($sformatf("rst_flags[%0d]", i), int'(eflg[i]), 0);
            check($sformatf("rst_moving[%0d]", i), int'(mov[i]), 0);
        end
        resetN = 1;
        tick();
        check_initial("idle", 0);
        model_reset();
        startOfFrame = 1;
        tick();
        startOfFrame = 0;
        check_initial("first_sof", 1);

        prev_tg = 0;
        for (int f = 0; f < 160; f++) begin
            if (f == 60 || f == 120) begin
                startOfFrame = 1; enable = 1;
                tick();
                startOfFrame = 0; restart = 1;
                tick();
                restart = 0;
                tick();
                check_initial("restart", 0);
                model_reset();
                startOfFrame = 1;
                tick();
                startOfFrame = 0;
            end
            k = $urandom_range(2, 6);
            for (int c = 0; c < k; c++) begin
                yk = ($urandom_range(0, 5) == 0);
                tg = !prev_tg && ($urandom_range(0, 5) == 0);
                cl = ($urandom_range(0, 5) == 0);
                hc = 4'($urandom_range(0, 15));
                ykey = yk; tkey = tg; coll = cl; code = hc;
                model_move(yk, tg, cl, hc);
                prev_tg = tg;
                tick();
            end
            ykey = 0; tkey = 0; coll = 0; code = '0; prev_tg = 0;
            en = ($urandom_range(0, 7) != 0);
            startOfFrame = 1; enable = en;
            if (en) begin
                for (int i = 0; i < 3; i++) model_frame(i, cyc + 4);
                waiting = 0;
            end
            tick();
            startOfFrame = 0; enable = 1;
            if (en) repeat (2) tick();
        end
        repeat (8) tick();
        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
